// File: rtl/multicycle_ctrl_v2.sv
// multicycle_ctrl_v2 -- multicycle MIPS-subset control FSM.
//
// Sits between the instruction register and the datapath and drives the mux
// selects, memory strobes and RF/PC/IR enables. Memory accesses complete on
// mem_ready; branch PC enables are resolved internally from zero.
//
// Optional feature: define MULTICYCLE_CTRL_INSTR_CNT_EN to add the
// retired-instruction counter and its instr_cnt port.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   opcode     IR[31:26], stable from DECODE onward
//   funct      IR[5:0]
//   zero       ALU zero flag
//   mem_ready  memory completes the current access this cycle
//   alusrcA    0=PC, 1=regA
//   alusrcB    00=regB, 01=4, 10=sign-ext imm, 11=shifted imm
//   aluop      00=add, 01=sub, 10=funct, 11=and
//   memread / memwrite  memory strobes
//   IorD       0=PC address, 1=ALUout address
//   IR_write   IR load
//   regwrite   register-file write
//   regdst     00=rt, 01=rd, 10=r31
//   memtoreg   00=ALUout, 01=MDR, 10=PC
//   pc_src     00=ALU, 01=ALUout, 10=jump target, 11=regA
//   pc_en      resolved PC write enable
//   illegal    sticky illegal-opcode trap flag
//   state      current state (debug)
//   instr_cnt  retired-instruction count (MULTICYCLE_CTRL_INSTR_CNT_EN only)
module multicycle_ctrl_v2 #(
  parameter int unsigned OPC_W   = 6,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned ALUOP_W = 2,
  parameter int unsigned STATE_W = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               alusrcA,
  output logic [1:0]         alusrcB,
  output logic [ALUOP_W-1:0] aluop,
  output logic               memread,
  output logic               memwrite,
  output logic               IorD,
  output logic               IR_write,
  output logic               regwrite,
  output logic [1:0]         regdst,
  output logic [1:0]         memtoreg,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               illegal,
  output logic [STATE_W-1:0] state
`ifdef MULTICYCLE_CTRL_INSTR_CNT_EN
  ,
  output logic [CNT_W-1:0]   instr_cnt
`endif
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    EXEC   = STATE_W'(2),
    MEM    = STATE_W'(3),
    MEM_WB = STATE_W'(4),
    ALU_WB = STATE_W'(5),
    TRAP   = STATE_W'(15)
  } state_t;

  localparam logic [OPC_W-1:0]   OP_RTYPE = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0]   OP_J     = OPC_W'(6'b000010);
  localparam logic [OPC_W-1:0]   OP_JAL   = OPC_W'(6'b000011);
  localparam logic [OPC_W-1:0]   OP_BEQ   = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0]   OP_BNE   = OPC_W'(6'b000101);
  localparam logic [OPC_W-1:0]   OP_ADDI  = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0]   OP_ANDI  = OPC_W'(6'b001100);
  localparam logic [OPC_W-1:0]   OP_LW    = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0]   OP_SW    = OPC_W'(6'b101011);
  localparam logic [FUNCT_W-1:0] FN_JR    = FUNCT_W'(6'b001000);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2'b11);

  state_t state_q, state_d;
  logic   illegal_q;
  logic   retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // TRAP is absorbing, so the flag stays set until reset.
      if (state_d == TRAP) illegal_q <= 1'b1;
    end
  end

  // Decoding is wrapped in the reset test so every output (including the
  // write enables) is forced low for as long as reset is held.
  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    alusrcA  = 1'b0;
    alusrcB  = 2'b00;
    aluop    = ALU_ADD;
    memread  = 1'b0;
    memwrite = 1'b0;
    IorD     = 1'b0;
    IR_write = 1'b0;
    regwrite = 1'b0;
    regdst   = 2'b00;
    memtoreg = 2'b00;
    pc_src   = 2'b00;
    pc_en    = 1'b0;
    if (reset) begin
      case (state_q)
        FETCH: begin
          memread = 1'b1;
          alusrcB = 2'b01;
          if (mem_ready) begin
            IR_write = 1'b1;
            pc_en    = 1'b1;
            state_d  = DECODE;
          end
        end
        DECODE: begin
          alusrcB = 2'b11;
          state_d = EXEC;
        end
        EXEC: begin
          if (opcode == OP_J) begin
            pc_src  = 2'b10;
            pc_en   = 1'b1;
            state_d = FETCH;
          end else if (opcode == OP_JAL) begin
            pc_src   = 2'b10;
            pc_en    = 1'b1;
            regwrite = 1'b1;
            regdst   = 2'b10;
            memtoreg = 2'b10;
            state_d  = FETCH;
          end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
            alusrcA = 1'b1;
            aluop   = ALU_SUB;
            pc_src  = 2'b01;
            pc_en   = (opcode == OP_BEQ) ? zero : ~zero;
            state_d = FETCH;
          end else if (opcode == OP_RTYPE && funct == FN_JR) begin
            pc_src  = 2'b11;
            pc_en   = 1'b1;
            state_d = FETCH;
          end else if (opcode == OP_RTYPE) begin
            alusrcA = 1'b1;
            aluop   = ALU_FN;
            state_d = ALU_WB;
          end else if (opcode == OP_ADDI || opcode == OP_ANDI) begin
            alusrcA = 1'b1;
            alusrcB = 2'b10;
            aluop   = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
            state_d = ALU_WB;
          end else if (opcode == OP_LW || opcode == OP_SW) begin
            alusrcA = 1'b1;
            alusrcB = 2'b10;
            state_d = MEM;
          end else begin
            state_d = TRAP;
          end
          retire = (state_d == FETCH);
        end
        MEM: begin
          IorD     = 1'b1;
          memread  = (opcode == OP_LW);
          memwrite = (opcode == OP_SW);
          if (mem_ready) begin
            state_d = (opcode == OP_LW) ? MEM_WB : FETCH;
            retire  = (opcode != OP_LW);
          end
        end
        MEM_WB: begin
          regwrite = 1'b1;
          memtoreg = 2'b01;
          state_d  = FETCH;
          retire   = 1'b1;
        end
        ALU_WB: begin
          regwrite = 1'b1;
          regdst   = (opcode == OP_RTYPE) ? 2'b01 : 2'b00;
          state_d  = FETCH;
          retire   = 1'b1;
        end
        TRAP: begin
          state_d = TRAP;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

`ifdef MULTICYCLE_CTRL_INSTR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign instr_cnt = cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Testbench for multicycle_ctrl_v2: per-instruction expected output traces
// are generated from the instruction rules and replayed cycle by cycle.
module tb_multicycle_ctrl_v2;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       alusrcA;
  logic [1:0] alusrcB;
  logic [1:0] aluop;
  logic       memread, memwrite, IorD, IR_write, regwrite;
  logic [1:0] regdst, memtoreg, pc_src;
  logic       pc_en, illegal;
  logic [3:0] state;
`ifdef MULTICYCLE_CTRL_INSTR_CNT_EN
  logic [31:0] instr_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl_v2 #(
    .OPC_W(6), .FUNCT_W(6), .ALUOP_W(2), .STATE_W(4), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alusrcA(alusrcA), .alusrcB(alusrcB), .aluop(aluop),
    .memread(memread), .memwrite(memwrite), .IorD(IorD), .IR_write(IR_write),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .pc_src(pc_src),
    .pc_en(pc_en), .illegal(illegal), .state(state)
`ifdef MULTICYCLE_CTRL_INSTR_CNT_EN
    , .instr_cnt(instr_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0] st;
    logic       a;
    logic [1:0] b;
    logic [1:0] op;
    logic       mr;
    logic       mw;
    logic       iord;
    logic       irw;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] m2r;
    logic [1:0] pcs;
    logic       pce;
    logic       ill;
  } outs_t;

  typedef struct {
    outs_t      e;
    logic       rdy;
    logic       z;
    logic [5:0] opc;
    logic [5:0] fn;
    bit         retire;
  } cyc_t;

  cyc_t        q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned exp_cnt  = 0;
  int unsigned pce_seen = 0;
  int unsigned memrd_seen = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.st = state;   o.a = alusrcA;  o.b = alusrcB;  o.op = aluop;
    o.mr = memread; o.mw = memwrite; o.iord = IorD; o.irw = IR_write;
    o.rw = regwrite; o.rd = regdst; o.m2r = memtoreg; o.pcs = pc_src;
    o.pce = pc_en;  o.ill = illegal;
    return o;
  endfunction

  function automatic outs_t blank(logic [3:0] st);
    outs_t o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic push(outs_t e, logic rdy, logic z, logic [5:0] opc,
                      logic [5:0] fn, bit retire);
    cyc_t c;
    c.e = e; c.rdy = rdy; c.z = z; c.opc = opc; c.fn = fn; c.retire = retire;
    q.push_back(c);
  endtask

  // Expected cycle-by-cycle trace of one instruction.
  // fw: fetch wait cycles, mw: memory wait cycles, tc: cycles to stay in TRAP.
  task automatic gen_instr(logic [5:0] opc, logic [5:0] fn, logic z,
                           int fw, int mw, int tc);
    outs_t o;
    int    kind; // 0 done in EXEC, 1 ALU writeback, 2 memory, 3 trap
    for (int i = 0; i <= fw; i++) begin
      o = blank(4'd0); o.mr = 1'b1; o.b = 2'b01;
      if (i == fw) begin o.irw = 1'b1; o.pce = 1'b1; end
      push(o, i == fw, z, opc, fn, 1'b0);
    end
    o = blank(4'd1); o.b = 2'b11;
    push(o, 1'b1, z, opc, fn, 1'b0);
    o = blank(4'd2);
    kind = 0;
    case (opc)
      6'd2: begin o.pcs = 2'b10; o.pce = 1'b1; end
      6'd3: begin
        o.pcs = 2'b10; o.pce = 1'b1; o.rw = 1'b1; o.rd = 2'b10; o.m2r = 2'b10;
      end
      6'd4, 6'd5: begin
        o.a = 1'b1; o.op = 2'b01; o.pcs = 2'b01;
        o.pce = (opc == 6'd4) ? z : !z;
      end
      6'd0: begin
        if (fn == 6'd8) begin o.pcs = 2'b11; o.pce = 1'b1; end
        else begin o.a = 1'b1; o.op = 2'b10; kind = 1; end
      end
      6'd8, 6'd12: begin
        o.a = 1'b1; o.b = 2'b10; o.op = (opc == 6'd12) ? 2'b11 : 2'b00; kind = 1;
      end
      6'd35, 6'd43: begin o.a = 1'b1; o.b = 2'b10; kind = 2; end
      default: kind = 3;
    endcase
    push(o, 1'b1, z, opc, fn, kind == 0);
    if (kind == 1) begin
      o = blank(4'd5); o.rw = 1'b1; o.rd = (opc == 6'd0) ? 2'b01 : 2'b00;
      push(o, 1'b1, z, opc, fn, 1'b1);
    end else if (kind == 2) begin
      for (int i = 0; i <= mw; i++) begin
        o = blank(4'd3); o.iord = 1'b1;
        o.mr = (opc == 6'd35); o.mw = (opc == 6'd43);
        push(o, i == mw, z, opc, fn, (opc == 6'd43) && (i == mw));
      end
      if (opc == 6'd35) begin
        o = blank(4'd4); o.rw = 1'b1; o.m2r = 2'b01;
        push(o, 1'b1, z, opc, fn, 1'b1);
      end
    end else if (kind == 3) begin
      for (int i = 0; i < tc; i++) begin
        o = blank(4'd15); o.ill = 1'b1;
        push(o, 1'b1, z, opc, fn, 1'b0);
      end
    end
  endtask

  // Replays up to n queued cycles; entered and left at posedge+1.
  task automatic play(int n);
    cyc_t  c;
    outs_t act;
    while (q.size() > 0 && n > 0) begin
      c = q.pop_front();
      n--;
      mem_ready = c.rdy; zero = c.z; opcode = c.opc; funct = c.fn;
      @(negedge clk);
      act = sample();
      chk($sformatf("outs_st%0d_op%0d", c.e.st, c.opc), 64'(act), 64'(c.e));
      if (act.pce) pce_seen++;
      if (act.mr && act.iord) memrd_seen++;
`ifdef MULTICYCLE_CTRL_INSTR_CNT_EN
      chk("instr_cnt", 64'(instr_cnt), 64'(exp_cnt));
`endif
      @(posedge clk);
      #1;
      if (c.retire) exp_cnt++;
    end
  endtask

  task automatic do_reset(int n);
    reset = 1'b0;
    q.delete();
    exp_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("reset_outs", 64'(sample()), 64'(0));
`ifdef MULTICYCLE_CTRL_INSTR_CNT_EN
      chk("reset_instr_cnt", 64'(instr_cnt), 64'(0));
`endif
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b1; opcode = 6'd0; funct = 6'h20; zero = 1'b0;
    #1;
    do_reset(2);

    // add: 0,1,2,5 with a single pc_en pulse in FETCH
    gen_instr(6'd0, 6'h20, 1'b0, 0, 0, 0);
    chk("add_len", 64'(q.size()), 64'd4);
    pce_seen = 0;
    play(100);
    chk("add_pc_en_pulses", 64'(pce_seen), 64'd1);

    // lw with 3 memory wait cycles
    gen_instr(6'd35, 6'd0, 1'b0, 0, 3, 0);
    chk("lw_wait_len", 64'(q.size()), 64'd8);
    memrd_seen = 0;
    play(100);
    chk("lw_memread_cycles", 64'(memrd_seen), 64'd4);

    gen_instr(6'd4, 6'd0, 1'b1, 0, 0, 0);
    chk("beq_len", 64'(q.size()), 64'd3);
    play(100);
    gen_instr(6'd5, 6'd0, 1'b1, 0, 0, 0);
    play(100);
    gen_instr(6'd4, 6'd0, 1'b0, 0, 0, 0);
    play(100);
    gen_instr(6'd5, 6'd0, 1'b0, 0, 0, 0);
    play(100);
    gen_instr(6'd0, 6'd8, 1'b0, 0, 0, 0);
    chk("jr_len", 64'(q.size()), 64'd3);
    play(100);
    gen_instr(6'd3, 6'd0, 1'b0, 0, 0, 0);
    play(100);
    gen_instr(6'd8, 6'd0, 1'b0, 0, 0, 0);
    play(100);
    gen_instr(6'd12, 6'd0, 1'b1, 0, 0, 0);
    play(100);
    gen_instr(6'd43, 6'd0, 1'b0, 0, 0, 0);
    chk("sw_len", 64'(q.size()), 64'd4);
    play(100);
    gen_instr(6'd43, 6'd0, 1'b0, 0, 2, 0);
    play(100);
    gen_instr(6'd35, 6'd0, 1'b0, 0, 0, 0);
    chk("lw_len", 64'(q.size()), 64'd5);
    play(100);
    gen_instr(6'd0, 6'h22, 1'b0, 2, 0, 0);
    chk("sub_fetchwait_len", 64'(q.size()), 64'd6);
    play(100);
    gen_instr(6'd2, 6'd0, 1'b0, 0, 0, 0);
    play(100);

    // retired count over add, lw, sw, beq, j
    do_reset(1);
    gen_instr(6'd0, 6'h20, 1'b0, 0, 0, 0);
    gen_instr(6'd35, 6'd0, 1'b0, 0, 1, 0);
    gen_instr(6'd43, 6'd0, 1'b0, 0, 0, 0);
    gen_instr(6'd4, 6'd0, 1'b1, 0, 0, 0);
    gen_instr(6'd2, 6'd0, 1'b0, 0, 0, 0);
    play(1000);
`ifdef MULTICYCLE_CTRL_INSTR_CNT_EN
    @(negedge clk);
    chk("instr_cnt_five", 64'(instr_cnt), 64'd5);
    @(posedge clk);
    #1;
`endif

    // reset asserted while lw waits in MEM
    gen_instr(6'd35, 6'd0, 1'b0, 0, 3, 0);
    play(5);
    do_reset(2);

    // illegal opcode: trap held for 10 cycles, cleared only by reset
    gen_instr(6'h3f, 6'd0, 1'b0, 0, 0, 10);
    chk("trap_len", 64'(q.size()), 64'd13);
    play(100);
    @(negedge clk);
    chk("trap_illegal_held", 64'(illegal), 64'd1);
    chk("trap_state_held", 64'(state), 64'd15);
    @(posedge clk);
    #1;
    do_reset(1);
    @(negedge clk);
    chk("post_trap_illegal", 64'(illegal), 64'd0);
    chk("post_trap_state", 64'(state), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_v2.md
Name: multicycle_ctrl_v2

Overview:
- Parametrised multicycle MIPS-subset control FSM; next generation of the team's multicycle controller.
- Sits between the instruction register and datapath. Drives the mux selects, memory strobes and register-file/PC/IR enables.
- New over the previous generation:
  - variable-latency memory handshake (mem_ready)
  - internal PC-enable resolution for beq/bne
  - jr decoded via funct
  - jal link write
  - illegal-opcode trap

Parameters:
- OPC_W, 6, opcode width
- FUNCT_W, 6, funct field width
- ALUOP_W, 2, width of aluop to ALU control
- STATE_W, 4, state register width (>=4)
- CNT_W, 32, retired-instruction counter width (INSTR_CNT_EN only)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  OPC_W  IR[31:26], stable from DECODE onward
- funct  in  FUNCT_W  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- alusrcA  out  1  0=PC, 1=regA
- alusrcB  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=shifted imm
- aluop  out  ALUOP_W  00=add, 01=sub, 10=funct, 11=and
- memread, memwrite  out  1 each  memory strobes
- IorD  out  1  0=PC address, 1=ALUout address
- IR_write  out  1  IR load
- regwrite  out  1  register-file write
- regdst  out  2  00=rt, 01=rd, 10=r31
- memtoreg  out  2  00=ALUout, 01=MDR, 10=PC
- pc_src  out  2  00=ALU, 01=ALUout, 10=jump target, 11=regA
- pc_en  out  1  resolved PC write enable
- illegal  out  1  sticky trap flag
- state  out  STATE_W  current state, debug
- instr_cnt  out  CNT_W  retired count (INSTR_CNT_EN only)

Behaviour:
- Outputs are combinational from state, opcode, funct, zero and mem_ready. Any output not listed for a state is 0. While reset is low, all outputs are 0 and state = FETCH (0).
- FETCH (0):
  - Always: memread=1, IorD=0, alusrcA=0, alusrcB=01, aluop=00, pc_src=00.
  - When mem_ready=1: IR_write=1, pc_en=1, next state DECODE.
  - Otherwise: hold FETCH with no IR/PC write.
- DECODE (1): alusrcA=0, alusrcB=11, aluop=00; next state EXEC.
- EXEC (2), by opcode:
  - j 000010: pc_src=10, pc_en=1 -> FETCH.
  - jal 000011: pc_src=10, pc_en=1, regwrite=1, regdst=10, memtoreg=10 -> FETCH.
  - beq 000100: alusrcA=1, alusrcB=00, aluop=01, pc_src=01, pc_en=zero -> FETCH.
  - bne 000101: same as beq but pc_en=~zero -> FETCH.
  - R-type 000000 with funct 001000 (jr): pc_src=11, pc_en=1 -> FETCH.
  - Other R-type: alusrcA=1, alusrcB=00, aluop=10 -> ALU_WB.
  - addi 001000: alusrcA=1, alusrcB=10, aluop=00 -> ALU_WB.
  - andi 001100: alusrcA=1, alusrcB=10, aluop=11 -> ALU_WB.
  - lw 100011 / sw 101011: alusrcA=1, alusrcB=10, aluop=00 -> MEM.
  - Any other opcode -> TRAP.
- MEM (3): IorD=1; memread=1 for lw, memwrite=1 for sw. Hold until mem_ready=1, then lw -> MEM_WB, sw -> FETCH. The strobe stays asserted every wait cycle.
- MEM_WB (4): regwrite=1, regdst=00, memtoreg=01 -> FETCH.
- ALU_WB (5): regwrite=1, memtoreg=00; regdst=01 for R-type, 00 for addi/andi -> FETCH.
- TRAP (15):
  - illegal=1, all other outputs 0.
  - Absorbing: leaves only on reset.
  - illegal is registered: set on entry, cleared only by reset.
- Instruction latencies with zero memory wait:
  - j/jal/jr/beq/bne: 3 cycles
  - R/addi/andi: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
  - Each wait cycle (mem_ready=0) adds 1.
- Unused state encodings -> FETCH on the next edge.
- Reset asserted mid-instruction: state immediately FETCH, outputs 0. No partial write may occur after reset assertion.

Optional Feature:
- Macro: MULTICYCLE_CTRL_INSTR_CNT_EN.
- Defined: instr_cnt port exists.
  - instr_cnt increments by 1 on each transition back to FETCH from EXEC, MEM (sw), MEM_WB or ALU_WB.
  - Wraps modulo 2^CNT_W.
  - Reset value 0. Never increments in TRAP.
- Undefined: port and counter logic absent; all other behaviour identical.

Test Plan:
- Reset low for 2 cycles, then release with mem_ready=1 and opcode=000000 (add) -> state sequence 0,1,2,5,0. In ALU_WB: regwrite=1, regdst=01. Exactly one pc_en pulse, in FETCH.
- lw with mem_ready held 0 for 3 cycles in MEM -> memread=1, IorD=1 for 4 cycles. Then MEM_WB with memtoreg=01, regwrite=1. Total 8 cycles.
- beq with zero=1, then bne with zero=1 -> pc_en=1, pc_src=01 for beq; pc_en=0 for bne. Both return to FETCH after EXEC.
- opcode 000000/funct 001000 -> EXEC pc_src=11, pc_en=1, no regwrite. jal -> regdst=10, memtoreg=10, regwrite=1, pc_en=1.
- opcode 111111 -> state 15 and illegal=1, held for 10 cycles; reset pulse -> illegal=0, state 0.
- With MULTICYCLE_CTRL_INSTR_CNT_EN: run 5 instructions (add, lw, sw, beq, j) -> instr_cnt=5. Assert reset mid-lw -> instr_cnt=0, all outputs 0 during reset.
